// File: rtl/morse_rx_if.sv
// rtl/morse_rx_if.sv - keying input and decoded-letter outputs of the Morse receiver
interface morse_rx_if;
    logic       key;
    logic [3:0] letter;
    logic       letter_valid;
    logic       letter_error;
    logic       busy;

    modport master (
        input  key,
        output letter,
        output letter_valid,
        output letter_error,
        output busy
    );

    modport slave (
        output key,
        input  letter,
        input  letter_valid,
        input  letter_error,
        input  busy
    );
endinterface

// File: rtl/morse_rx.sv
// rtl/morse_rx.sv - on/off keying receiver: times marks/gaps, collects symbols, decodes A..H
module morse_rx #(
    parameter int UNIT_CYCLES = 4,
    parameter int DASH_MIN    = 2 * UNIT_CYCLES,
    parameter int LETTER_GAP  = 3 * UNIT_CYCLES,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         reset,
    morse_rx_if.master   rx
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP - 1);

    state_t           state_q;
    logic             key_meta_q;
    logic             key_s_q;
    logic [CNT_W-1:0] mark_cnt_q;
    logic [CNT_W-1:0] gap_cnt_q;
    logic [3:0]       sym_bits_q;
    logic [2:0]       sym_cnt_q;
    logic             overflow_q;
    logic [3:0]       letter_q;
    logic             valid_q;
    logic             error_q;
    logic             busy_q;

    logic             dec_ok;
    logic [3:0]       dec_idx;

    // Symbols sit LSB-first with 1=dot; bits above sym_cnt are always 0.
    always_comb begin
        dec_ok  = 1'b1;
        dec_idx = 4'd0;
        case ({sym_cnt_q, sym_bits_q})
            {3'd2, 4'b0001}: dec_idx = 4'd0;
            {3'd4, 4'b1110}: dec_idx = 4'd1;
            {3'd4, 4'b1010}: dec_idx = 4'd2;
            {3'd3, 4'b0110}: dec_idx = 4'd3;
            {3'd1, 4'b0001}: dec_idx = 4'd4;
            {3'd4, 4'b1011}: dec_idx = 4'd5;
            {3'd3, 4'b0100}: dec_idx = 4'd6;
            {3'd4, 4'b1111}: dec_idx = 4'd7;
            default:         dec_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            mark_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sym_bits_q <= 4'd0;
            sym_cnt_q  <= 3'd0;
            overflow_q <= 1'b0;
            letter_q   <= 4'd0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            key_meta_q <= rx.key;
            key_s_q    <= key_meta_q;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_s_q) begin
                        state_q    <= MARK;
                        mark_cnt_q <= CNT_W'(1);
                        busy_q     <= 1'b1;
                    end
                end
                MARK: begin
                    if (key_s_q) begin
                        if (mark_cnt_q != CNT_MAX)
                            mark_cnt_q <= mark_cnt_q + 1'b1;
                    end else begin
                        if (sym_cnt_q < 3'd4) begin
                            sym_bits_q[sym_cnt_q[1:0]] <= (mark_cnt_q < DASH_TH);
                            sym_cnt_q <= sym_cnt_q + 3'd1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        gap_cnt_q <= CNT_W'(1);
                        state_q   <= SPACE;
                    end
                end
                SPACE: begin
                    if (key_s_q) begin
                        state_q    <= MARK;
                        mark_cnt_q <= CNT_W'(1);
                    end else if (gap_cnt_q == GAP_LAST) begin
                        if (dec_ok && !overflow_q) begin
                            letter_q <= dec_idx;
                            valid_q  <= 1'b1;
                        end else begin
                            error_q  <= 1'b1;
                        end
                        sym_bits_q <= 4'd0;
                        sym_cnt_q  <= 3'd0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.letter       = letter_q;
    assign rx.letter_valid = valid_q;
    assign rx.letter_error = error_q;
    assign rx.busy         = busy_q;
endmodule
